// File: rtl/sub_borrow_pkg.sv
// Shared types and sizing helpers for the chunk-serial subtract-with-borrow unit.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
package sub_borrow_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of CHUNK-wide slices making up one WIDTH-wide operand.
    function automatic int slice_count(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Slice counter width; never narrower than one bit so N=1 still has a counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sub_borrow_slice.sv
// One CHUNK-bit slice of a - b - bin, producing the slice difference and its borrow out.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the sequencer decides when the result is consumed.
module sub_borrow_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] diff,
    output logic             bout
);

    logic [CHUNK:0] wide;

    // A one-bit-wider subtraction leaves the borrow in the top bit.
    always_comb begin
        wide = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};
        diff = wide[CHUNK-1:0];
        bout = wide[CHUNK];
    end

endmodule

// File: rtl/sub_borrow_seq.sv
// Chunk-serial d = a - b - bin over WIDTH bits, CHUNK bits per cycle LSB first; SUB_BORROW_SEQ_OVF_EN adds signed overflow output ovf.
// Latency: out_valid rises WIDTH/CHUNK clock edges after the input accept edge.
// Backpressure: result (d, bout, ovf) held in DONE until out_ready; in_ready low in RUN and DONE, no queueing.
module sub_borrow_seq
    import sub_borrow_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SUB_BORROW_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = slice_count(WIDTH, CHUNK);
    localparam int CW = cnt_width(N);

    if ((WIDTH % CHUNK) != 0) begin : g_width_check
        $error("sub_borrow_seq: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] d_r;
    logic             brw;
    logic             bout_r;
    logic [CW-1:0]    cnt;
    logic             last_slice;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK-1:0] diff_sl;
    logic             bo_sl;
`ifdef SUB_BORROW_SEQ_OVF_EN
    logic             ovf_r;
`endif

    assign last_slice = (cnt == CW'(N - 1));

    // State register; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; the output handshake never overlaps an accept.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last_slice) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Select the operand slice addressed by the counter.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt == CW'(k)) begin
                a_sl = a_r[k*CHUNK +: CHUNK];
                b_sl = b_r[k*CHUNK +: CHUNK];
            end
        end
    end

    sub_borrow_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .bin  (brw),
        .diff (diff_sl),
        .bout (bo_sl)
    );

    // Operand capture on accept, then one slice per RUN cycle written back in place.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r    <= '0;
            b_r    <= '0;
            d_r    <= '0;
            brw    <= 1'b0;
            bout_r <= 1'b0;
            cnt    <= '0;
`ifdef SUB_BORROW_SEQ_OVF_EN
            ovf_r  <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (in_valid) begin
                a_r <= a;
                b_r <= b;
                brw <= bin;
                cnt <= '0;
            end
        end else if (state == RUN) begin
            for (int k = 0; k < N; k++) begin
                if (cnt == CW'(k)) d_r[k*CHUNK +: CHUNK] <= diff_sl;
            end
            brw <= bo_sl;
            cnt <= cnt + 1'b1;
            if (last_slice) begin
                bout_r <= bo_sl;
`ifdef SUB_BORROW_SEQ_OVF_EN
                // Operands of differing sign whose result sign differs from the minuend.
                ovf_r  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_sl[CHUNK-1] != a_r[WIDTH-1]);
`endif
            end
        end
    end

    assign d    = d_r;
    assign bout = bout_r;
`ifdef SUB_BORROW_SEQ_OVF_EN
    assign ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_sub_borrow_seq.sv
// Directed bench for sub_borrow_seq at WIDTH=32, CHUNK=8 (four slices).
// Latency: checks out_valid arrives exactly four edges after accept.
// Backpressure: holds out_ready low and checks the result stays put.
module tb_sub_borrow_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] d;
    logic        bout;
`ifdef SUB_BORROW_SEQ_OVF_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    sub_borrow_seq #(
        .WIDTH (32),
        .CHUNK (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout)
`ifdef SUB_BORROW_SEQ_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one operation, scramble the inputs after the accept edge, and check latency.
    task automatic issue(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                         input logic tbin);
        int cyc;
        @(negedge clk);
        check({tag, " in_ready before accept"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        bin      = tbin;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'h1234_5678;
        bin      = ~tbin;
        cyc      = 0;
        while (cyc < 50) begin
            @(posedge clk);
            cyc++;
            #1;
            if (out_valid) break;
        end
        check({tag, " latency"}, 32'(cyc), 32'd4);
    endtask

    // Consume the result and confirm the unit returns to idle.
    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " out_valid after handshake"}, {31'd0, out_valid}, 32'd0);
        check({tag, " in_ready after handshake"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;

        #1;
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset d", d, 32'd0);
        check("reset bout", {31'd0, bout}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        issue("10-3", 32'd10, 32'd3, 1'b0);
        check("10-3 d", d, 32'h0000_0007);
        check("10-3 bout", {31'd0, bout}, 32'd0);
        handshake("10-3");

        issue("3-10", 32'd3, 32'd10, 1'b0);
        check("3-10 d", d, 32'hFFFF_FFF9);
        check("3-10 bout", {31'd0, bout}, 32'd1);
        handshake("3-10");

        issue("xchunk", 32'h0000_0100, 32'h0000_0001, 1'b1);
        check("xchunk d", d, 32'h0000_00FE);
        check("xchunk bout", {31'd0, bout}, 32'd0);
        handshake("xchunk");

        issue("0-0-1", 32'd0, 32'd0, 1'b1);
        check("0-0-1 d", d, 32'hFFFF_FFFF);
        check("0-0-1 bout", {31'd0, bout}, 32'd1);
        handshake("0-0-1");

        // Backpressure: result held for five cycles while a second request is ignored.
        issue("bp", 32'h1234_5678, 32'h1111_1111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = 32'h0000_0001;
            b        = 32'h0000_0002;
            bin      = 1'b1;
            check("bp d held", d, 32'h0123_4567);
            check("bp bout held", {31'd0, bout}, 32'd0);
            check("bp out_valid held", {31'd0, out_valid}, 32'd1);
            check("bp in_ready low", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        handshake("bp");
        repeat (2) @(negedge clk);
        check("bp d after handshake", d, 32'h0123_4567);
        check("bp no ghost op", {31'd0, in_ready}, 32'd1);

        // Reset mid-operation after two slices have been processed.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'hFFFF_FFFF;
        b        = 32'h0000_0001;
        bin      = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst d", d, 32'd0);
        check("midrst bout", {31'd0, bout}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        issue("5-5", 32'd5, 32'd5, 1'b0);
        check("5-5 d", d, 32'd0);
        check("5-5 bout", {31'd0, bout}, 32'd0);
        handshake("5-5");

`ifdef SUB_BORROW_SEQ_OVF_EN
        issue("ovf min-1", 32'h8000_0000, 32'd1, 1'b0);
        check("ovf min-1 d", d, 32'h7FFF_FFFF);
        check("ovf min-1 ovf", {31'd0, ovf}, 32'd1);
        check("ovf min-1 bout", {31'd0, bout}, 32'd0);
        handshake("ovf min-1");

        issue("ovf 5-3", 32'd5, 32'd3, 1'b0);
        check("ovf 5-3 d", d, 32'd2);
        check("ovf 5-3 ovf", {31'd0, ovf}, 32'd0);
        handshake("ovf 5-3");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sub_borrow_seq.md
Name: sub_borrow_seq

Overview:
- Chunk-serial subtract-with-borrow unit: d = a - b - bin over WIDTH bits, with borrow out. The inverse operation to the team's add-with-carry datapath.
- Processes CHUNK bits per cycle, LSB first, to trade latency for area in the decode-system ALU path.
- Valid/ready handshake on both input and output sides.
- Sits beside the adder-with-carry unit, fed by operand decode; results go to writeback.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CHUNK, 8, bits processed per cycle. WIDTH % CHUNK must equal 0, otherwise elaboration error via $error.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  unit can accept operands.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- d  out  WIDTH  difference, a - b - bin mod 2^WIDTH.
- bout  out  1  borrow out; 1 iff a < b + bin (unsigned).
- ovf  out  1  signed overflow; present only with SUB_BORROW_SEQ_OVF_EN.

Behaviour:
- Reset (reset==0, async): state IDLE, in_ready=1, out_valid=0, d=0, bout=0, ovf=0, slice counter=0. Any in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: capture a, b, bin into internal registers, borrow reg <= bin, counter <= 0, go to RUN.
  - Inputs changed after the accept edge are ignored.
- RUN:
  - in_ready=0.
  - Each cycle k (k = 0..N-1, N = WIDTH/CHUNK): slice [k*CHUNK +: CHUNK] = a_slice - b_slice - borrow, written into d at the same position; borrow reg <= slice borrow out.
  - After slice N-1: bout <= final borrow, out_valid <= 1, go to DONE.
- Latency: out_valid rises N clock edges after the accept edge (4 for the defaults).
- DONE:
  - out_valid=1; d, bout and ovf held stable while out_ready=0 (backpressure of arbitrary length).
  - On out_ready: out_valid <= 0, go to IDLE.
  - in_ready stays 0 in DONE. No accept can occur in the same cycle as the output handshake; the minimum issue interval is N+2 cycles.
- d holds its last result after the handshake until the next operation overwrites it slice by slice. d is defined only while out_valid=1.
- in_valid during RUN or DONE is ignored; no queueing.
- N=1 (CHUNK==WIDTH) is legal: RUN lasts one cycle.

Optional Feature:
- Macro SUB_BORROW_SEQ_OVF_EN.
- Defined: port ovf exists. It is set at the final slice as a[W-1] != b[W-1] && d[W-1] != a[W-1], with bin included in the subtraction. Reset 0; held with d.
- Undefined: port ovf and its logic are absent. Everything else is identical.

Decomposition:
- Shared package sub_borrow_pkg:
  - state enum typedef {IDLE, RUN, DONE}.
  - Function/constant for slice count N = WIDTH/CHUNK.
  - Counter width $clog2(N) (minimum 1).
- Sub-module sub_borrow_slice: combinational CHUNK-bit a - b - bin with borrow out. Instantiated once and muxed by the counter.

Test Plan (WIDTH=32, CHUNK=8):
- a=10, b=3, bin=0 -> d=0x00000007, bout=0, out_valid exactly 4 cycles after accept.
- a=3, b=10, bin=0 -> d=0xFFFFFFF9, bout=1.
- Cross-chunk borrow: a=0x00000100, b=0x00000001, bin=1 -> d=0x000000FE, bout=0. Also a=0, b=0, bin=1 -> d=0xFFFFFFFF, bout=1.
- Backpressure:
  - out_ready held 0 for 5 cycles after out_valid: d and bout stable, in_ready=0, a second in_valid is ignored.
  - out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset asserted in RUN after slice 1:
  - Immediately out_valid=0, in_ready=1, d=0, bout=0.
  - A new op a=5, b=5, bin=0 after release -> d=0, bout=0.
- With SUB_BORROW_SEQ_OVF_EN:
  - a=0x80000000, b=1, bin=0 -> d=0x7FFFFFFF, ovf=1, bout=0.
  - a=5, b=3 -> ovf=0.
